div_mod_sequencer: RTL and testbench

- Multi-cycle sequencer for the calculator's Divide and Modulo operations, which the single-cycle ALU cannot complete in one state.
- The top controller pulses `start` on entering its Divide/Modulo state and waits in that state until `done`.
- Internally runs a restoring shift-subtract loop, one quotient bit per clock.
- Owns its operand, partial-remainder and quotient registers; returns quotient or remainder as selected.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/div_mod_sequencer_if.sv | 32 +++
 rtl/div_step.sv | 30 +++
 rtl/div_mod_sequencer.sv | 118 +++++++++++
 tb/tb_div_mod_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// calc_pkg : shared calculator constants, mode codes and sequencer states
// Revision : 1.0
// ---------------------------------------------------------------------------
package calc_pkg;

  localparam int DEF_WIDTH = 8;

  // Mode-select codes continuing the single-cycle ALU codes 3'b001..3'b100.
  localparam logic [2:0] MS_DIV = 3'b101;
  localparam logic [2:0] MS_MOD = 3'b110;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t ST_IDLE = 2'd0;
  localparam seq_state_t ST_RUN  = 2'd1;
  localparam seq_state_t ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/div_mod_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_mod_sequencer_if : request/response bundle between controller and divider
// Revision : 1.0
// ---------------------------------------------------------------------------
interface div_mod_sequencer_if
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic             op_mod;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, op_mod, dividend, divisor,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, op_mod, dividend, divisor,
    output busy, done, result, div_by_zero
  );

endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_step : one combinational restoring shift-subtract iteration
// Revision : 1.0
// ---------------------------------------------------------------------------
module div_step
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_next_o,
  output logic [WIDTH-1:0] quo_next_o
);

  // One guard bit above the shifted remainder so its sign is the borrow.
  logic [WIDTH+1:0] shifted_w;
  logic [WIDTH+1:0] trial_w;
  logic             borrow_w;

  assign shifted_w  = {rem_i, quo_i[WIDTH-1]};
  assign trial_w    = shifted_w - {2'b00, divisor_i};
  assign borrow_w   = trial_w[WIDTH+1];
  assign rem_next_o = borrow_w ? shifted_w[WIDTH:0] : trial_w[WIDTH:0];
  assign quo_next_o = {quo_i[WIDTH-2:0], ~borrow_w};

endmodule
`default_nettype wire

// File: rtl/div_mod_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_mod_sequencer : multi-cycle unsigned divide / modulo, one bit per clock
// Revision : 1.0
// ---------------------------------------------------------------------------
module div_mod_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                CLK,
  input  logic                RST_n,
  div_mod_sequencer_if.slave  seq_if
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  seq_state_t       state_q,  state_d;
  logic [WIDTH:0]   rem_q,    rem_d;
  logic [WIDTH-1:0] quo_q,    quo_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             op_mod_q, op_mod_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q,    dbz_d;

  logic [WIDTH:0]   step_rem_w;
  logic [WIDTH-1:0] step_quo_w;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i      (rem_q),
    .quo_i      (quo_q),
    .divisor_i  (divisor_q),
    .rem_next_o (step_rem_w),
    .quo_next_o (step_quo_w)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    op_mod_d  = op_mod_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    dbz_d     = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (seq_if.start) begin
          op_mod_d  = seq_if.op_mod;
          divisor_d = seq_if.divisor;
          if (seq_if.divisor == '0) begin
            state_d  = ST_DONE;
            dbz_d    = 1'b1;
            result_d = seq_if.op_mod ? seq_if.dividend : '1;
          end else begin
            state_d = ST_RUN;
            rem_d   = '0;
            quo_d   = seq_if.dividend;
            cnt_d   = CNT_W'(WIDTH);
          end
        end
      end

      ST_RUN: begin
        rem_d = step_rem_w;
        quo_d = step_quo_w;
        cnt_d = cnt_q - CNT_W'(1);
        // Result is taken straight from the final step so it is valid in DONE.
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          dbz_d    = 1'b0;
          result_d = op_mod_q ? step_rem_w[WIDTH-1:0] : step_quo_w;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      op_mod_q  <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      op_mod_q  <= op_mod_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      dbz_q     <= dbz_d;
    end
  end

  assign seq_if.busy        = (state_q != ST_IDLE);
  assign seq_if.done        = (state_q == ST_DONE);
  assign seq_if.result      = result_q;
  assign seq_if.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_mod_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_div_mod_sequencer : directed + random checks of 8-bit and 4-bit dividers
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_div_mod_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  div_mod_sequencer_if #(.WIDTH(8)) if8 ();
  div_mod_sequencer_if #(.WIDTH(4)) if4 ();

  div_mod_sequencer #(.WIDTH(8)) u_dut8 (
    .CLK    (clk),
    .RST_n  (rst_n),
    .seq_if (if8)
  );

  div_mod_sequencer #(.WIDTH(4)) u_dut4 (
    .CLK    (clk),
    .RST_n  (rst_n),
    .seq_if (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w4, input bit s, input int a, input int b, input bit m);
    if (w4) begin
      if4.start    = s;
      if4.dividend = 4'(a);
      if4.divisor  = 4'(b);
      if4.op_mod   = m;
    end else begin
      if8.start    = s;
      if8.dividend = 8'(a);
      if8.divisor  = 8'(b);
      if8.op_mod   = m;
    end
  endtask

  function automatic logic [31:0] get_busy(input bit w4);
    return w4 ? 32'(if4.busy) : 32'(if8.busy);
  endfunction
  function automatic logic [31:0] get_done(input bit w4);
    return w4 ? 32'(if4.done) : 32'(if8.done);
  endfunction
  function automatic logic [31:0] get_res(input bit w4);
    return w4 ? 32'(if4.result) : 32'(if8.result);
  endfunction
  function automatic logic [31:0] get_dbz(input bit w4);
    return w4 ? 32'(if4.div_by_zero) : 32'(if8.div_by_zero);
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge following done.
  task automatic run_op(input bit w4, input int a, input int b, input bit m,
                        input bit repulse, input string tag);
    int width;
    int all_ones;
    int exp_res;
    int exp_lat;
    int cyc;
    width    = w4 ? 4 : 8;
    all_ones = (1 << width) - 1;
    if (b == 0) begin
      exp_res = m ? a : all_ones;
      exp_lat = 1;
    end else begin
      exp_res = m ? (a % b) : (a / b);
      exp_lat = width + 1;
    end

    drive(w4, 1'b1, a, b, m);
    @(posedge clk);
    #1;
    drive(w4, 1'b0, a, b, m);
    cyc = 1;
    chk({tag, " busy"}, get_busy(w4), 32'd1);
    while (get_done(w4) !== 32'd1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (repulse && (cyc == 3 || cyc == 8))
        drive(w4, 1'b1, int'($urandom_range(0, all_ones)), int'($urandom_range(1, all_ones)), ~m);
      else
        drive(w4, 1'b0, a, b, m);
    end
    chk({tag, " done"},    get_done(w4), 32'd1);
    chk({tag, " latency"}, 32'(cyc),     32'(exp_lat));
    chk({tag, " result"},  get_res(w4),  32'(exp_res));
    chk({tag, " dbz"},     get_dbz(w4),  32'(b == 0));
    @(posedge clk);
    #1;
    chk({tag, " done_pulse"}, get_done(w4), 32'd0);
    chk({tag, " idle_busy"},  get_busy(w4), 32'd0);
    chk({tag, " held"},       get_res(w4),  32'(exp_res));
  endtask

  int  ra;
  int  rb;
  bit  rm;
  bit  saw_done;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy8",   get_busy(1'b0), 32'd0);
    chk("rst done8",   get_done(1'b0), 32'd0);
    chk("rst result8", get_res(1'b0),  32'd0);
    chk("rst dbz8",    get_dbz(1'b0),  32'd0);
    chk("rst busy4",   get_busy(1'b1), 32'd0);
    chk("rst result4", get_res(1'b1),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(1'b0, 100, 7, 1'b0, 1'b0, "100/7");
    run_op(1'b0, 100, 7, 1'b1, 1'b0, "100%7");
    run_op(1'b0, 255, 1, 1'b0, 1'b0, "255/1");
    run_op(1'b0, 5,   9, 1'b0, 1'b0, "5/9");
    run_op(1'b0, 5,   9, 1'b1, 1'b0, "5%9");
    run_op(1'b0, 42,  0, 1'b0, 1'b0, "42/0");
    run_op(1'b0, 42,  0, 1'b1, 1'b0, "42%0");
    run_op(1'b0, 100, 7, 1'b0, 1'b1, "100/7 repulse");
    run_op(1'b0, 200, 9, 1'b1, 1'b0, "back2back 200%9");

    // Reset asserted mid-run must clear outputs at once and suppress done.
    run_op(1'b0, 100, 7, 1'b0, 1'b0, "pre-reset 100/7");
    drive(1'b0, 1'b1, 100, 7, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 100, 7, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy",   get_busy(1'b0), 32'd0);
    chk("midrst result", get_res(1'b0),  32'd0);
    chk("midrst done",   get_done(1'b0), 32'd0);
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (get_done(1'b0) === 32'd1) saw_done = 1'b1;
    end
    chk("midrst no_done", 32'(saw_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(1'b0, 200, 3, 1'b0, 1'b0, "post-reset 200/3");

    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      rm = 1'($urandom_range(0, 1));
      run_op(1'b0, ra, rb, rm, 1'($urandom_range(0, 1)), $sformatf("rand8 %0d,%0d,%0d", ra, rb, rm));
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int m = 0; m < 2; m++) begin
          run_op(1'b1, a, b, 1'(m), 1'b0, $sformatf("w4 %0d,%0d,%0d", a, b, m));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
